// File: rtl/maze_pkg.sv
// Shared types for the maze cell store: cell codes, phase encoding,
// and default geometry.
package maze_pkg;

  localparam int MAZE_W = 6;
  localparam int CELL_W = 2;

  localparam logic [CELL_W-1:0] CELL_FREE = 2'd0;
  localparam logic [CELL_W-1:0] CELL_WALL = 2'd1;
  localparam logic [CELL_W-1:0] CELL_PATH = 2'd2;

  typedef enum logic [1:0] {
    PH_LOAD,
    PH_SERVE,
    PH_DUMP,
    PH_FIN
  } phase_e;

endpackage

// File: rtl/maze_ram.sv
// Single-port read-first cell RAM; a protected write leaves WALL
// cells untouched and wall_o flags the addressed cell's current code.
module maze_ram
  import maze_pkg::*;
#(
  parameter int AW = 12,
  parameter int DW = 2
) (
  input  logic          clk_i,
  input  logic          re_i,
  input  logic          we_i,
  input  logic          keep_wall_i,
  input  logic [AW-1:0] addr_i,
  input  logic [DW-1:0] wdata_i,
  output logic [DW-1:0] rdata_o,
  output logic          wall_o
);

  logic [DW-1:0] mem_q [2**AW];
  logic [DW-1:0] rdata_q;

  assign wall_o  = (mem_q[addr_i] == DW'(CELL_WALL));
  assign rdata_o = rdata_q;

  always_ff @(posedge clk_i) begin
    if (re_i) begin
      rdata_q <= mem_q[addr_i];
    end
    if (we_i && !(keep_wall_i && wall_o)) begin
      mem_q[addr_i] <= wdata_i;
    end
  end

endmodule

// File: rtl/maze_store.sv
// Maze cell store: serial load, solver read/mark service, then a
// row-major dump of the annotated maze.
module maze_store
  import maze_pkg::*;
#(
  parameter int maze_width = MAZE_W,
  parameter int cell_width = CELL_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load_valid,
  output logic                  load_ready,
  input  logic                  load_data,
  output logic                  maze_ready,
  input  logic [maze_width-1:0] row,
  input  logic [maze_width-1:0] col,
  input  logic                  maze_oe,
  input  logic                  maze_we,
  output logic                  maze_in,
  input  logic                  done,
  output logic                  dump_valid,
  input  logic                  dump_ready,
  output logic [cell_width-1:0] dump_data,
  output logic                  dump_last,
  output logic                  wr_err,
  output logic                  finished
);

  localparam int AW = 2 * maze_width;
  localparam logic [AW-1:0] LAST = '1;

  phase_e          state_q, state_d;
  logic [AW-1:0]   cnt_q, cnt_d;
  logic            lrdy_q, lrdy_d;
  logic            rvld_q, rvld_d;
  logic            dvld_q, dvld_d;
  logic            err_q, err_d;

  logic                  ram_re;
  logic                  ram_we;
  logic                  ram_keep;
  logic [AW-1:0]         ram_addr;
  logic [cell_width-1:0] ram_wdata;
  logic [cell_width-1:0] ram_rdata;
  logic                  ram_wall;

  maze_ram #(
    .AW(AW),
    .DW(cell_width)
  ) u_ram (
    .clk_i      (clk),
    .re_i       (ram_re),
    .we_i       (ram_we),
    .keep_wall_i(ram_keep),
    .addr_i     (ram_addr),
    .wdata_i    (ram_wdata),
    .rdata_o    (ram_rdata),
    .wall_o     (ram_wall)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rvld_d    = rvld_q;
    dvld_d    = dvld_q;
    err_d     = err_q;
    ram_re    = 1'b0;
    ram_we    = 1'b0;
    ram_keep  = 1'b0;
    ram_addr  = cnt_q;
    ram_wdata = cell_width'(CELL_FREE);
    unique case (state_q)
      PH_LOAD: begin
        if (load_valid && lrdy_q) begin
          ram_we    = 1'b1;
          ram_wdata = load_data ? cell_width'(CELL_WALL)
                                : cell_width'(CELL_FREE);
          cnt_d     = cnt_q + AW'(1);
          if (cnt_q == LAST) begin
            state_d = PH_SERVE;
          end
        end
      end
      PH_SERVE: begin
        ram_addr  = {row, col};
        ram_re    = maze_oe;
        ram_we    = maze_we;
        ram_keep  = 1'b1;
        ram_wdata = cell_width'(CELL_PATH);
        if (maze_oe) begin
          rvld_d = 1'b1;
        end
        if (maze_we && ram_wall) begin
          err_d = 1'b1;
        end
        if (done) begin
          state_d = PH_DUMP;
          rvld_d  = 1'b0;
          cnt_d   = '0;
        end
      end
      PH_DUMP: begin
        // rdata_q doubles as the output word; it only reloads on advance
        if (!dvld_q) begin
          ram_re = 1'b1;
          dvld_d = 1'b1;
        end else if (dump_ready) begin
          if (cnt_q == LAST) begin
            dvld_d  = 1'b0;
            state_d = PH_FIN;
          end else begin
            ram_re   = 1'b1;
            ram_addr = cnt_q + AW'(1);
            cnt_d    = cnt_q + AW'(1);
          end
        end
      end
      PH_FIN: begin
      end
      default: begin
        state_d = PH_LOAD;
      end
    endcase
    lrdy_d = (state_d == PH_LOAD);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= PH_LOAD;
      cnt_q   <= '0;
      lrdy_q  <= 1'b0;
      rvld_q  <= 1'b0;
      dvld_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      lrdy_q  <= lrdy_d;
      rvld_q  <= rvld_d;
      dvld_q  <= dvld_d;
      err_q   <= err_d;
    end
  end

  assign load_ready = lrdy_q;
  assign maze_ready = (state_q == PH_SERVE);
  assign maze_in    = rvld_q && (ram_rdata == cell_width'(CELL_WALL));
  assign dump_valid = dvld_q;
  assign dump_data  = dvld_q ? ram_rdata : '0;
  assign dump_last  = dvld_q && (cnt_q == LAST);
  assign wr_err     = err_q;
  assign finished   = (state_q == PH_FIN);

endmodule

// File: tb/tb_maze_store.sv
// Scoreboard bench for maze_store: random mazes and solver traffic
// against an array model of the cell contents.
module tb_maze_store;
  import maze_pkg::*;

  localparam int N = 4096;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       load_valid = 1'b0;
  logic       load_ready;
  logic       load_data = 1'b0;
  logic       maze_ready;
  logic [5:0] row = '0;
  logic [5:0] col = '0;
  logic       maze_oe = 1'b0;
  logic       maze_we = 1'b0;
  logic       maze_in;
  logic       done = 1'b0;
  logic       dump_valid;
  logic       dump_ready = 1'b0;
  logic [1:0] dump_data;
  logic       dump_last;
  logic       wr_err;
  logic       finished;

  maze_store dut (
    .clk(clk), .rst_n(rst_n),
    .load_valid(load_valid), .load_ready(load_ready),
    .load_data(load_data), .maze_ready(maze_ready),
    .row(row), .col(col), .maze_oe(maze_oe), .maze_we(maze_we),
    .maze_in(maze_in), .done(done),
    .dump_valid(dump_valid), .dump_ready(dump_ready),
    .dump_data(dump_data), .dump_last(dump_last),
    .wr_err(wr_err), .finished(finished)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int model [N];
  bit exp_err = 1'b0;
  int rdq [$];
  int dq [$];
  int last_in = 0;
  bit serving = 1'b0;
  int dump_idx = 0;
  bit rd_s, hold_s;

  task automatic chk(string nm, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // maze_in monitor: pops on every read, checks hold otherwise
  always @(posedge clk) begin
    rd_s   = rst_n && serving && maze_oe;
    hold_s = rst_n && serving && !maze_oe;
    #2;
    if (rd_s) begin
      if (rdq.size() == 0) begin
        chk("maze_in_unexpected", 1, 0);
      end else begin
        last_in = rdq.pop_front();
        chk("maze_in", maze_in, last_in);
      end
    end else if (hold_s) begin
      chk("maze_in_hold", maze_in, last_in);
    end
  end

  // dump monitor: peeks while stalled, pops on handshake
  always @(negedge clk) begin
    if (rst_n && dump_valid) begin
      if (dq.size() == 0) begin
        chk("dump_extra", 1, 0);
      end else begin
        chk("dump_data", dump_data, dq[0]);
        chk("dump_last", dump_last, int'(dump_idx == N - 1));
        if (dump_ready) begin
          void'(dq.pop_front());
          dump_idx++;
        end
      end
    end
  end

  task automatic build_maze();
    for (int a = 0; a < N; a++) begin
      int r, c;
      bit w;
      r = a / 64;
      c = a % 64;
      if (r == 0 || r == 63 || c == 0 || c == 63) w = !(r == 0 && c == 5);
      else if ((r == 1 && c == 1) || (r == 2 && c == 3) || (r == 4 && c == 4)) w = 1'b0;
      else w = ($urandom_range(0, 4) == 0);
      model[a] = w ? 1 : 0;
    end
  endtask

  task automatic do_load(bit done_noise);
    int a, t;
    bit acc;
    build_maze();
    t = 0;
    while (!load_ready && t < 10) begin
      step();
      t++;
    end
    chk("load_ready_up", load_ready, 1);
    a = 0;
    t = 0;
    while (a < N && t < 3 * N) begin
      load_data  = model[a][0];
      load_valid = ($urandom_range(0, 3) != 0);
      done       = done_noise && (a < 50);
      acc        = load_valid && load_ready;
      if (acc && a == N - 1) chk("maze_ready_pre", maze_ready, 0);
      step();
      t++;
      if (acc) begin
        a++;
        if (a == N) begin
          chk("maze_ready_rise", maze_ready, 1);
          chk("load_ready_fall", load_ready, 0);
        end
      end
    end
    load_valid = 1'b0;
    done = 1'b0;
    chk("load_complete", a, N);
  endtask

  task automatic wait_serve();
    int t;
    t = 0;
    while (!maze_ready && t < 10) begin
      step();
      t++;
    end
    chk("serve_entered", maze_ready, 1);
    last_in = 0;
    serving = 1'b1;
  endtask

  task automatic op(int r, int c, bit oe, bit we);
    int a;
    a = r * 64 + c;
    row = 6'(r);
    col = 6'(c);
    maze_oe = oe;
    maze_we = we;
    if (oe) rdq.push_back(int'(model[a] == 1));
    if (we) begin
      if (model[a] == 1) exp_err = 1'b1;
      else model[a] = 2;
    end
    step();
    maze_oe = 1'b0;
    maze_we = 1'b0;
  endtask

  task automatic rand_ops(int n);
    for (int i = 0; i < n; i++) begin
      op($urandom_range(0, 63), $urandom_range(0, 63),
         $urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0);
    end
  endtask

  task automatic start_dump();
    int t;
    serving = 1'b0;
    done = 1'b1;
    dq.delete();
    for (int a = 0; a < N; a++) dq.push_back(model[a]);
    dump_idx = 0;
    step();
    chk("maze_ready_fall", maze_ready, 0);
    t = 0;
    while (!dump_valid && t < 2) begin
      step();
      t++;
    end
    chk("dump_latency", dump_valid, 1);
  endtask

  task automatic finish_dump(int mode);
    int t;
    t = 0;
    while (!finished && t < 20000) begin
      dump_ready = (mode == 0) ? ~dump_ready : 1'($urandom_range(0, 1));
      step();
      t++;
    end
    dump_ready = 1'b0;
    chk("finished", finished, 1);
    chk("dump_drained", dq.size(), 0);
    chk("fin_dump_valid", dump_valid, 0);
    chk("fin_dump_last", dump_last, 0);
    chk("fin_dump_data", dump_data, 0);
    chk("fin_maze_ready", maze_ready, 0);
    chk("fin_load_ready", load_ready, 0);
    chk("fin_maze_in", maze_in, 0);
    chk("fin_wr_err", wr_err, int'(exp_err));
  endtask

  task automatic chk_reset_outs(string tag);
    chk({tag, "_load_ready"}, load_ready, 0);
    chk({tag, "_maze_ready"}, maze_ready, 0);
    chk({tag, "_maze_in"}, maze_in, 0);
    chk({tag, "_dump_valid"}, dump_valid, 0);
    chk({tag, "_dump_last"}, dump_last, 0);
    chk({tag, "_dump_data"}, dump_data, 0);
    chk({tag, "_wr_err"}, wr_err, 0);
    chk({tag, "_finished"}, finished, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int t;
    rst_n = 1'b0;
    repeat (3) step();
    chk_reset_outs("rst");
    rst_n = 1'b1;

    do_load(1'b0);
    wait_serve();
    op(0, 0, 1, 0);
    op(1, 1, 1, 0);
    op(int'(6'(0 - 1)), 7, 1, 0);
    op(0, 5, 1, 0);
    op(2, 3, 0, 1);
    op(2, 3, 1, 0);
    chk("wr_err_clean", wr_err, 0);
    op(0, 0, 0, 1);
    chk("wr_err_set", wr_err, 1);
    op(0, 0, 1, 0);
    op(4, 4, 1, 1);
    op(4, 4, 1, 0);
    rand_ops(400);
    chk("wr_err_serve", wr_err, int'(exp_err));
    start_dump();
    finish_dump(0);

    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    exp_err = 1'b0;
    do_load(1'b1);
    wait_serve();
    op(0, 0, 0, 1);
    rand_ops(50);
    start_dump();
    dump_ready = 1'b1;
    t = 0;
    while (dump_idx < 100 && t < 1000) begin
      step();
      t++;
    end
    chk("dump_reached_100", int'(dump_idx >= 100), 1);
    rst_n = 1'b0;
    dump_ready = 1'b0;
    step();
    dq.delete();
    chk_reset_outs("abort");
    rst_n = 1'b1;
    exp_err = 1'b0;

    do_load(1'b0);
    wait_serve();
    op(0, 0, 1, 0);
    op(0, 5, 1, 0);
    op(63, 63, 1, 0);
    rand_ops(50);
    start_dump();
    finish_dump(1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
